// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: forward-mux encodings, producer
// result distances and default mult/div latencies.
package hazard_scoreboard_pkg;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  // Cycles from E entry until the producer's result can be forwarded
  localparam int TNEW_ALU  = 1;
  localparam int TNEW_LD   = 2;
  localparam int TNEW_LINK = 0;

  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_DIV_LAT  = 10;

  function automatic int max_lat(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_md_counter.sv
// Mult/div occupancy counter: loads the unit latency on an accepted start and
// counts down to idle; busy while nonzero.
module hazard_md_counter
  import hazard_scoreboard_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start_i,
  input  logic div_i,
  input  logic stall_i,
  output logic busy_o
);

  localparam int MAX_LAT = max_lat(MULT_LAT, DIV_LAT);
  localparam int CW      = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // A stalled start is not accepted; it is re-presented once D advances
  always_comb begin
    cnt_d = cnt_q;
    if (start_i && !stall_i) begin
      cnt_d = div_i ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks E/M/W producers, raises stall for data
// and mult/div hazards and picks the forwarding source per D-stage operand.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_SRC  = 2,
  parameter int REG_AW   = 5,
  parameter int TW       = 2,
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr_d,
  input  logic [NUM_SRC*TW-1:0]     src_tuse_d,
  input  logic [NUM_SRC-1:0]        src_vld_d,
  input  logic [REG_AW-1:0]         dst_addr_d,
  input  logic                      dst_we_d,
  input  logic [TW-1:0]             tnew_d,
  input  logic                      md_start_d,
  input  logic                      md_div_d,
  input  logic                      md_use_d,
  input  logic                      flush_e,
  output logic                      stall,
  output logic                      bubble_e,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      md_busy
);

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] addr;
    logic [TW-1:0]     tnew;
  } entry_t;

  entry_t e_q, m_q, w_q;
  entry_t e_d, m_d, w_d;

  logic               live_e, live_m, live_w;
  logic [NUM_SRC-1:0] src_haz;
  logic               md_haz;

  function automatic entry_t aged(input entry_t x);
    entry_t r;
    r = x;
    if (x.tnew != '0) begin
      r.tnew = x.tnew - TW'(1);
    end
    return r;
  endfunction

  // Register 0 is hardwired, so a write to it never produces a hazard
  assign live_e = e_q.we && (e_q.addr != '0);
  assign live_m = m_q.we && (m_q.addr != '0);
  assign live_w = w_q.we && (w_q.addr != '0);

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [REG_AW-1:0] addr;
    logic [TW-1:0]     tuse;
    logic              hit_e, hit_m, hit_w;
    logic [1:0]        sel;

    assign addr  = src_addr_d[gi*REG_AW +: REG_AW];
    assign tuse  = src_tuse_d[gi*TW +: TW];
    assign hit_e = live_e && (e_q.addr == addr);
    assign hit_m = live_m && (m_q.addr == addr);
    assign hit_w = live_w && (w_q.addr == addr);

    // W is never a stall source: by then every producer has tnew 0 or is
    // already covered by the stall raised while it sat in E or M
    assign src_haz[gi] = src_vld_d[gi] &&
                         ((hit_e && (e_q.tnew > tuse)) ||
                          (hit_m && (m_q.tnew > tuse)));

    // The youngest match shadows older ones even when it is not ready yet
    always_comb begin
      sel = FWD_RF;
      if (hit_e) begin
        sel = (e_q.tnew == '0) ? FWD_E : FWD_RF;
      end else if (hit_m) begin
        sel = (m_q.tnew == '0) ? FWD_M : FWD_RF;
      end else if (hit_w) begin
        sel = (w_q.tnew == '0) ? FWD_W : FWD_RF;
      end
    end

    assign fwd_sel[gi*2 +: 2] = sel;
  end

  assign md_haz   = md_use_d && md_busy;
  assign stall    = (|src_haz) || md_haz;
  assign bubble_e = stall || flush_e;

  always_comb begin
    e_d = '0;
    if (!bubble_e) begin
      e_d.we   = dst_we_d;
      e_d.addr = dst_addr_d;
      e_d.tnew = tnew_d;
    end
    m_d = aged(e_q);
    w_d = aged(m_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  hazard_md_counter #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (md_start_d),
    .div_i   (md_div_d),
    .stall_i (stall),
    .busy_o  (md_busy)
  );

endmodule
